// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch BCD counter.
//   DIGIT_W   : width of one BCD digit
//   BCD_MAX   : largest legal BCD digit value
//   BCD_MIN   : smallest legal BCD digit value
//   bcd_clamp : forces a non-decimal nibble (A..F) down to 9
package stopwatch_pkg;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_MIN = 4'd0;

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch counter: a single 4-bit register that
// loads a (clamped) preset or steps up/down by one when its carry/borrow
// input is set. Carry/borrow out is combinational so digits ripple.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset, clears the digit
//   load_i     : load clamped preset_i (takes priority over stepping)
//   up_i       : 1 = increment, 0 = decrement
//   cin_i      : carry (up) or borrow (down) from the lower digit
//   preset_i   : preset nibble
//   digit_o    : registered digit value
//   cout_o     : carry/borrow into the next digit
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               up_i,
  input  logic               cin_i,
  input  logic [DIGIT_W-1:0] preset_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               cout_o
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    cout_o  = 1'b0;
    if (load_i) begin
      digit_d = bcd_clamp(preset_i);
    end else if (cin_i) begin
      if (up_i) begin
        // >= rather than == keeps an out-of-range value from running past 9
        if (digit_q >= BCD_MAX) begin
          digit_d = BCD_MIN;
          cout_o  = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == BCD_MIN) begin
          digit_d = BCD_MAX;
          cout_o  = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Multi-digit BCD up/down stopwatch counter with tick prescaler, preset
// load, lap latch and wrap carry pulse.
//   sys_clk     : system clock, rising edge
//   reset       : asynchronous active-high reset
//   count_init  : load preset_val (digits clamped to 9), clear prescaler
//   count_enb   : enable prescaler and counting
//   count_up    : 1 = count up, 0 = count down
//   latch_count : lap request, rising edge captures the current count
//   preset_val  : BCD preset
//   count_out   : live BCD count (registered)
//   latch_out   : last captured lap value (registered)
//   latch_valid : one-cycle pulse when latch_out updates
//   carry_out   : one-cycle pulse on wrap (999..->000.. or 000..->999..)
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1,
  parameter int PS_W     = 16
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      count_init,
  input  logic                      count_enb,
  input  logic                      count_up,
  input  logic                      latch_count,
  input  logic [DIGIT_W*DIGITS-1:0] preset_val,
  output logic [DIGIT_W*DIGITS-1:0] count_out,
  output logic [DIGIT_W*DIGITS-1:0] latch_out,
  output logic                      latch_valid,
  output logic                      carry_out
);

  localparam int              CW      = DIGIT_W * DIGITS;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Prescaler: wraps at PRESCALE-1 and emits the tick in that same cycle.
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  assign tick = count_enb && (ps_q == PS_LAST);

  always_comb begin
    ps_d = ps_q;
    if (count_init)     ps_d = '0;
    else if (tick)      ps_d = '0;
    else if (count_enb) ps_d = ps_q + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) ps_q <= '0;
    else       ps_q <= ps_d;
  end

  // Digit chain: cy[0] is the tick (suppressed by a load), each digit
  // ripples its carry/borrow into the next; cy[DIGITS] is the wrap.
  logic [DIGITS:0] cy;
  logic [CW-1:0]   cnt;

  assign cy[0] = tick && !count_init;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i    (sys_clk),
      .rst_i    (reset),
      .load_i   (count_init),
      .up_i     (count_up),
      .cin_i    (cy[g]),
      .preset_i (preset_val[g*DIGIT_W +: DIGIT_W]),
      .digit_o  (cnt[g*DIGIT_W +: DIGIT_W]),
      .cout_o   (cy[g+1])
    );
  end

  assign count_out = cnt;

  // Lap latch and wrap flag. The edge detector resets to 0 so a request
  // held high through reset release captures once afterwards.
  logic          lat_prev_q;
  logic          lat_edge;
  logic [CW-1:0] latch_q, latch_d;
  logic          lvld_q, carry_q;

  assign lat_edge = latch_count && !lat_prev_q;
  assign latch_d  = lat_edge ? cnt : latch_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      lat_prev_q <= 1'b0;
      latch_q    <= '0;
      lvld_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      lat_prev_q <= latch_count;
      latch_q    <= latch_d;
      lvld_q     <= lat_edge;
      carry_q    <= cy[DIGITS];
    end
  end

  assign latch_out   = latch_q;
  assign latch_valid = lvld_q;
  assign carry_out   = carry_q;

endmodule
